uart_cmd_ctrl: RTL



---
 rtl/uart_ctrl_pkg.sv | 19 +
 rtl/pos_edge_detector_n.sv | 19 +
 rtl/uart_cmd_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared command/response codes and FSM state encoding for the UART command controller.
package uart_ctrl_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_DUMP = 8'h44;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [1:0] {
    ST_CMD  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/pos_edge_detector_n.sv
// Rising-edge detector: pulse is high for the single cycle in which sig_in first reads high.
module pos_edge_detector_n (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic pulse
);

  logic sig_q;

  // NOTE: asynchronous reset lives in the sensitivity list; state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_in;
  end

  assign pulse = sig_in & ~sig_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Host command decoder for the UART-programmable core: owns CPU reset, I-memory
// byte loading and D-memory dumping, answering LOAD/RUN/HALT with ACK or NAK.
module uart_cmd_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int IMEM_BYTE_ADDR_WIDTH = 6,
  parameter int DMEM_BYTE_ADDR_WIDTH = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx_ready,
  input  logic [7:0]                      rx_data,
  input  logic                            tx_empty,
  input  logic                            tx_error,
  output logic                            tx_req,
  output logic [7:0]                      tx_data,
  output logic                            cpu_rst,
  output logic                            imem_ctrl,
  output logic                            imem_wr_en,
  output logic [IMEM_BYTE_ADDR_WIDTH-1:0] imem_addr,
  output logic [7:0]                      imem_wr_data,
  output logic                            dmem_ctrl,
  output logic                            dmem_rd_en,
  output logic [DMEM_BYTE_ADDR_WIDTH-1:0] dmem_addr,
  input  logic [7:0]                      dmem_rd_data,
  output logic                            busy,
  output logic                            err
);

  localparam logic [IMEM_BYTE_ADDR_WIDTH-1:0] IMEM_LAST = '1;

  state_e                          state_q, state_d;
  logic                            running_q, running_d;
  logic                            tx_wait_q, tx_wait_d;
  logic                            tx_req_q, tx_req_d;
  logic [7:0]                      tx_data_q, tx_data_d;
  logic                            dmem_rd_en_q, dmem_rd_en_d;
  logic                            cap_q, cap_d;
  logic                            rsp_nak_q, rsp_nak_d;
  logic                            err_q, err_d;
  logic                            busy_q, busy_d;
  logic [IMEM_BYTE_ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [DMEM_BYTE_ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;

  logic rx_pulse;
  logic tx_empty_rise;
  logic send_ready;

  pos_edge_detector_n u_rx_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (rx_ready),
    .pulse  (rx_pulse)
  );

  pos_edge_detector_n u_tx_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (tx_empty),
    .pulse  (tx_empty_rise)
  );

  // tx_req_q covers the cycle before tx_wait_q catches up with the request.
  assign send_ready = tx_empty & ~tx_wait_q & ~tx_req_q;

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    running_d    = running_q;
    tx_wait_d    = tx_wait_q;
    tx_req_d     = 1'b0;
    tx_data_d    = tx_data_q;
    dmem_rd_en_d = 1'b0;
    cap_d        = 1'b0;
    rsp_nak_d    = rsp_nak_q;
    err_d        = err_q;
    imem_addr_d  = imem_addr_q;
    dmem_addr_d  = dmem_addr_q;

    if (tx_req_q)           tx_wait_d = 1'b1;
    else if (tx_empty_rise) tx_wait_d = 1'b0;

    case (state_q)
      ST_CMD: begin
        if (rx_pulse) begin
          case (rx_data)
            CMD_LOAD: begin
              running_d   = 1'b0;
              imem_addr_d = '0;
              state_d     = ST_LOAD;
            end
            CMD_RUN: begin
              running_d = 1'b1;
              rsp_nak_d = 1'b0;
              state_d   = ST_RESP;
            end
            CMD_HALT: begin
              running_d = 1'b0;
              rsp_nak_d = 1'b0;
              state_d   = ST_RESP;
            end
            CMD_DUMP: begin
              dmem_addr_d = '0;
              state_d     = ST_DUMP;
            end
            default: begin
              rsp_nak_d = 1'b1;
              state_d   = ST_RESP;
            end
          endcase
        end
      end

      ST_LOAD: begin
        if (rx_pulse) begin
          imem_addr_d = imem_addr_q + IMEM_BYTE_ADDR_WIDTH'(1);
          if (imem_addr_q == IMEM_LAST) begin
            rsp_nak_d = 1'b0;
            state_d   = ST_RESP;
          end
        end
      end

      ST_DUMP: begin
        if (tx_error) begin
          err_d     = 1'b1;
          tx_wait_d = 1'b0;
          state_d   = ST_CMD;
        end else begin
          if (rx_pulse)     err_d = 1'b1;
          if (dmem_rd_en_q) cap_d = 1'b1;
          if (cap_q) begin
            tx_data_d   = dmem_rd_data;
            tx_req_d    = 1'b1;
            dmem_addr_d = dmem_addr_q + DMEM_BYTE_ADDR_WIDTH'(1);
          end
          // Address has already wrapped to zero while the final byte's strobe is out.
          if (tx_req_q && dmem_addr_q == '0)
            state_d = ST_CMD;
          else if (send_ready && !dmem_rd_en_q && !cap_q)
            dmem_rd_en_d = 1'b1;
        end
      end

      ST_RESP: begin
        if (tx_error) begin
          err_d     = 1'b1;
          tx_wait_d = 1'b0;
          state_d   = ST_CMD;
        end else begin
          if (rx_pulse) err_d = 1'b1;
          if (send_ready) begin
            tx_data_d = rsp_nak_q ? RSP_NAK : RSP_ACK;
            tx_req_d  = 1'b1;
            state_d   = ST_CMD;
          end
        end
      end
    endcase

    busy_d = (state_d != ST_CMD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CMD;
      running_q    <= 1'b0;
      tx_wait_q    <= 1'b0;
      tx_req_q     <= 1'b0;
      tx_data_q    <= 8'h00;
      dmem_rd_en_q <= 1'b0;
      cap_q        <= 1'b0;
      rsp_nak_q    <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      imem_addr_q  <= '0;
      dmem_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      running_q    <= running_d;
      tx_wait_q    <= tx_wait_d;
      tx_req_q     <= tx_req_d;
      tx_data_q    <= tx_data_d;
      dmem_rd_en_q <= dmem_rd_en_d;
      cap_q        <= cap_d;
      rsp_nak_q    <= rsp_nak_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      imem_addr_q  <= imem_addr_d;
      dmem_addr_q  <= dmem_addr_d;
    end
  end

  // The write strobe is the raw byte pulse so the byte lands in the same cycle it arrives.
  assign imem_wr_en   = (state_q == ST_LOAD) & rx_pulse;
  assign imem_wr_data = rx_data;
  assign imem_addr    = imem_addr_q;

  assign cpu_rst      = ~running_q;
  assign imem_ctrl    = ~running_q;
  assign dmem_ctrl    = ~running_q;

  assign tx_req       = tx_req_q;
  assign tx_data      = tx_data_q;
  assign dmem_rd_en   = dmem_rd_en_q;
  assign dmem_addr    = dmem_addr_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule
